timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Control FSM for the team's programmable down-count timer.
- Sequences load, run, pause, expire and reload of a CNT_W-bit counter from one-shot or periodic start commands.
- Sits between the register/command interface and the flop-based counter datapath.
- Produces a single-cycle expiry pulse for the interrupt logic.

Parameters:
- CNT_W, 16, width of the count, load value and reload shadow register.
- PRESC_W, 8, width of the prescaler divider. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle command: load and run.
- stop  in  1  1-cycle command: abort to IDLE.
- pause  in  1  level: freeze counting while high.
- periodic  in  1  mode, sampled at start: 1 = auto-reload, 0 = one-shot.
- load_val  in  CNT_W  start value, sampled at start.
- count  out  CNT_W  current count, registered.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.
- expired  out  1  1-cycle pulse when count reaches 0.
- err  out  1  1-cycle pulse when start is rejected.
- state  out  2  encoded FSM state, for debug.

Behaviour:
- Reset values:
  - state = IDLE, count = 0.
  - busy, done, expired and err are all 0.
  - Shadow registers are cleared.
- States: IDLE(0), RUN(1), PAUSE(2), DONE(3).
- Priority, highest first: rst > stop > start > pause > tick.
- stop:
  - From any state, next cycle is state = IDLE and count = 0.
  - No expired pulse is generated.
  - stop and start in the same cycle: stop wins.
- start with load_val != 0, from any state:
  - Capture load_val into the shadow register and capture periodic.
  - Next cycle: count = load_val, state = RUN.
  - Applies to RUN, PAUSE and DONE too: start restarts the timer.
- start with load_val == 0:
  - Ignored; state and count are unchanged.
  - err pulses high in the next cycle.
- RUN:
  - count decrements by 1 on each tick.
  - Without the prescaler, tick occurs every cycle.
  - The first decrement happens in the cycle after the load cycle.
- Terminal condition in RUN: tick while count == 1.
  - In the next cycle, count = 0 and expired = 1 for exactly one cycle.
  - One-shot: state goes to DONE and holds count = 0.
  - Periodic: count = shadow value in the cycle after the zero cycle, and state stays RUN.
- Timing example, load_val = 3, start sampled in cycle N:

  | Cycle | count | expired |
  |---|---|---|
  | N+1 | 3 | 0 |
  | N+2 | 2 | 0 |
  | N+3 | 1 | 0 |
  | N+4 | 0 | 1 |

  - Periodic mode then reloads 3 in N+5.
- load_val = 1 gives: 1, then 0 with expired, then reload.
- pause:
  - While pause is high in RUN, next state = PAUSE and count is frozen.
  - pause low in PAUSE: return to RUN; counting resumes the cycle after.
  - pause has no effect in IDLE or DONE.
  - pause high on the terminal tick: the tick is not taken; count holds at 1.
- DONE: holds until start or stop.
- Counting is modulo-free: count never wraps below 0.
- rst mid-operation: next cycle equals the reset values; any pending expiry is discarded.

Optional Feature:
- Macro: TIMER_CTRL_PRESCALE_EN.
- Defined:
  - Adds input presc_val [PRESC_W], captured at start.
  - A divider counts 0..presc_val; tick asserts when divider == presc_val, then the divider wraps to 0.
  - The count therefore decrements every presc_val+1 cycles.
  - The divider clears on start, stop and rst, and holds during PAUSE.
  - presc_val = 0 is equivalent to no prescaling.
- Undefined:
  - No presc_val port and no divider logic.
  - tick = 1 in every RUN cycle.

Decomposition:
- Shared package timer_pkg contains:
  - typedef enum logic [1:0] timer_state_e {IDLE, RUN, PAUSE, DONE};
  - Default CNT_W and PRESC_W localparams.
- Sub-module timer_prescaler (divider plus tick generation):
  - Instantiated only under TIMER_CTRL_PRESCALE_EN.
  - Ports: clk, rst, clr, hold, presc_val, tick.

Test Plan:
1. One-shot: rst, then start with load_val = 3, periodic = 0.
   - count 3, 2, 1, 0 in cycles N+1 to N+4.
   - expired = 1 only in N+4.
   - done = 1 from N+4 onward; busy = 0 from N+4.
2. Periodic: load_val = 2, periodic = 1, run 8 cycles.
   - count sequence 2, 1, 0, 2, 1, 0, 2.
   - expired pulses every 3 cycles.
3. Pause: load_val = 5; raise pause at count = 3 for 4 cycles.
   - state = PAUSE and count holds at 3.
   - After release, counting resumes at 3, 2, ...
   - Total cycles to expiry is 4 more than unpaused.
4. Command conflicts:
   - start with load_val = 0: err pulse, state stays IDLE.
   - start and stop in the same cycle during RUN: IDLE, count = 0, no expired.
   - start during RUN at count 4 with load_val = 9: count = 9 next cycle.
5. Reset mid-run: assert rst at count = 2.
   - Next cycle: state IDLE, count 0, all outputs 0.
   - No expired pulse afterwards.
6. TIMER_CTRL_PRESCALE_EN: presc_val = 2, load_val = 2.
   - count decrements every 3 cycles.
   - expired occurs 7 cycles after the load cycle.
   - The divider holds during pause.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and default widths for the programmable down-count timer.
// Optional prescaler is enabled with the TIMER_CTRL_PRESCALE_EN macro.
package timer_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int PRESC_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// Command/status bundle between the register block and timer_ctrl.
// presc_val exists only when TIMER_CTRL_PRESCALE_EN is defined.
interface timer_ctrl_if #(
    parameter int CNT_W = timer_pkg::CNT_W_DEF
`ifdef TIMER_CTRL_PRESCALE_EN
    , parameter int PRESC_W = timer_pkg::PRESC_W_DEF
`endif
);
    // start/stop are single-cycle command strobes with no back-pressure: the
    // timer acts on every cycle they are high. pause is a level. Status
    // outputs are registered and valid every cycle; expired/err are 1-cycle.
    logic             start;
    logic             stop;
    logic             pause;
    logic             periodic;
    logic [CNT_W-1:0] load_val;
`ifdef TIMER_CTRL_PRESCALE_EN
    logic [PRESC_W-1:0] presc_val;
`endif
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             expired;
    logic             err;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, periodic, load_val,
`ifdef TIMER_CTRL_PRESCALE_EN
        output presc_val,
`endif
        input  count, busy, done, expired, err, state
    );

    modport slave (
        input  start, stop, pause, periodic, load_val,
`ifdef TIMER_CTRL_PRESCALE_EN
        input  presc_val,
`endif
        output count, busy, done, expired, err, state
    );

endinterface

// File: rtl/timer_prescaler.sv
// Tick divider: counts 0..presc_val and emits tick on the terminal value.
// Only instantiated when TIMER_CTRL_PRESCALE_EN is defined.
module timer_prescaler #(
    parameter int PRESC_W = timer_pkg::PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               hold,
    input  logic [PRESC_W-1:0] presc_val,
    output logic               tick
);

    logic [PRESC_W-1:0] div_q;

    assign tick = (div_q == presc_val);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_q <= '0;
        end else if (!hold) begin
            div_q <= tick ? '0 : div_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Control FSM for the down-count timer: load, run, pause, expire, reload.
// Build option: TIMER_CTRL_PRESCALE_EN adds a captured prescaler on the tick.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef TIMER_CTRL_PRESCALE_EN
    , parameter int PRESC_W = PRESC_W_DEF
`endif
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             periodic_q, periodic_d;
    logic             expired_q, expired_d;
    logic             err_q, err_d;

    logic start_ok;
    logic active;
    logic tick;

    assign start_ok = bus.start && (bus.load_val != '0);
    // Counting is live in RUN, and also on the cycle PAUSE is released.
    assign active   = ((state_q == RUN) || (state_q == PAUSE)) && !bus.pause;

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (!bus.stop && start_ok) begin
            presc_q <= bus.presc_val;
        end
    end

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.stop || start_ok),
        .hold      (!active),
        .presc_val (presc_q),
        .tick      (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        periodic_d = periodic_q;
        expired_d  = 1'b0;
        err_d      = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start_ok) begin
            state_d    = RUN;
            count_d    = bus.load_val;
            shadow_d   = bus.load_val;
            periodic_d = bus.periodic;
        end else begin
            // A rejected start does not disturb whatever the timer is doing.
            err_d = bus.start;
            case (state_q)
                RUN, PAUSE: begin
                    if (!active) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                        if (count_q == '0) begin
                            count_d = shadow_q;
                        end else if (tick) begin
                            if (count_q == CNT_W'(1)) begin
                                count_d   = '0;
                                expired_d = 1'b1;
                                if (!periodic_q) begin
                                    state_d = DONE;
                                end
                            end else begin
                                count_d = count_q - CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shadow_q   <= '0;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
            err_q      <= err_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = (state_q == RUN) || (state_q == PAUSE);
    assign bus.done    = (state_q == DONE);
    assign bus.expired = expired_q;
    assign bus.err     = err_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl; the prescaler scenario runs
// only when TIMER_CTRL_PRESCALE_EN is defined.
module tb_timer_ctrl;

    localparam int CW = 16;
    localparam int W  = 2 + 4 + CW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic clk = 1'b0;
    logic rst;

    timer_ctrl_if bus_if ();

    timer_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        lbl_q[$];
    int           tests_run = 0;
    int           failed    = 0;

    // Expected outputs; busy/done follow directly from the state definition.
    function automatic logic [W-1:0] mk(input logic [1:0] s, input logic [CW-1:0] c,
                                        input logic e, input logic r);
        logic b, d;
        b = (s == S_RUN) || (s == S_PAUSE);
        d = (s == S_DONE);
        return {s, b, d, e, r, c};
    endfunction

    task automatic drive(input string lbl, input logic r, input logic st, input logic sp,
                         input logic pa, input logic per, input logic [CW-1:0] lv,
                         input logic [1:0] es, input logic [CW-1:0] ec,
                         input logic ee, input logic er);
        @(negedge clk);
        rst             = r;
        bus_if.start    = st;
        bus_if.stop     = sp;
        bus_if.pause    = pa;
        bus_if.periodic = per;
        bus_if.load_val = lv;
        exp_q.push_back(mk(es, ec, ee, er));
        lbl_q.push_back(lbl);
    endtask

    task automatic cyc(input string lbl, input logic st, input logic sp, input logic pa,
                       input logic per, input logic [CW-1:0] lv,
                       input logic [1:0] es, input logic [CW-1:0] ec,
                       input logic ee, input logic er);
        drive(lbl, 1'b0, st, sp, pa, per, lv, es, ec, ee, er);
    endtask

    task automatic idle(input string lbl, input logic [1:0] es, input logic [CW-1:0] ec,
                        input logic ee);
        drive(lbl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, es, ec, ee, 1'b0);
    endtask

    // Monitor: one registered output set per cycle, compared after the edge.
    initial begin : monitor
        logic [W-1:0] got, e;
        string        l;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                l   = lbl_q.pop_front();
                got = {bus_if.state, bus_if.busy, bus_if.done, bus_if.expired,
                       bus_if.err, bus_if.count};
                tests_run++;
                if (got !== e) begin
                    failed++;
                    $display("FAIL %s: got st=%0d busy=%b done=%b exp=%b err=%b cnt=%0d, want st=%0d busy=%b done=%b exp=%b err=%b cnt=%0d",
                             l, got[W-1:W-2], got[W-3], got[W-4], got[W-5], got[W-6], got[CW-1:0],
                             e[W-1:W-2], e[W-3], e[W-4], e[W-5], e[W-6], e[CW-1:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        rst             = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.stop     = 1'b0;
        bus_if.pause    = 1'b0;
        bus_if.periodic = 1'b0;
        bus_if.load_val = '0;
`ifdef TIMER_CTRL_PRESCALE_EN
        bus_if.presc_val = '0;
`endif
        drive("reset0", 1'b1, 0, 0, 0, 0, '0, S_IDLE, 0, 0, 0);
        drive("reset1", 1'b1, 0, 0, 0, 0, '0, S_IDLE, 0, 0, 0);

        // One-shot, load 3
        cyc ("os_load", 1, 0, 0, 0, 16'd3, S_RUN, 3, 0, 0);
        idle("os_2", S_RUN, 2, 0);
        idle("os_1", S_RUN, 1, 0);
        idle("os_exp", S_DONE, 0, 1);
        idle("os_hold", S_DONE, 0, 0);
        cyc ("done_pause", 0, 0, 1, 0, '0, S_DONE, 0, 0, 0);

        // Periodic, load 2, restarted from DONE
        cyc ("per_load", 1, 0, 0, 1, 16'd2, S_RUN, 2, 0, 0);
        idle("per_1a", S_RUN, 1, 0);
        idle("per_0a", S_RUN, 0, 1);
        idle("per_rl_a", S_RUN, 2, 0);
        idle("per_1b", S_RUN, 1, 0);
        idle("per_0b", S_RUN, 0, 1);
        idle("per_rl_b", S_RUN, 2, 0);
        idle("per_1c", S_RUN, 1, 0);
        cyc ("per_stop", 0, 1, 0, 0, '0, S_IDLE, 0, 0, 0);
        cyc ("idle_pause", 0, 0, 1, 0, '0, S_IDLE, 0, 0, 0);

        // Pause at count 3 for 4 cycles
        cyc ("pz_load", 1, 0, 0, 0, 16'd5, S_RUN, 5, 0, 0);
        idle("pz_4", S_RUN, 4, 0);
        idle("pz_3", S_RUN, 3, 0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("pz_hold%0d", i), 0, 0, 1, 0, '0, S_PAUSE, 3, 0, 0);
        idle("pz_res2", S_RUN, 2, 0);
        idle("pz_res1", S_RUN, 1, 0);
        idle("pz_exp", S_DONE, 0, 1);

        // Command conflicts
        cyc ("cf_stop", 0, 1, 0, 0, '0, S_IDLE, 0, 0, 0);
        cyc ("cf_zero", 1, 0, 0, 0, 16'd0, S_IDLE, 0, 0, 1);
        idle("cf_zero_after", S_IDLE, 0, 0);
        cyc ("cf_load6", 1, 0, 0, 0, 16'd6, S_RUN, 6, 0, 0);
        cyc ("cf_st_sp", 1, 1, 0, 0, 16'd6, S_IDLE, 0, 0, 0);
        idle("cf_st_sp_after", S_IDLE, 0, 0);
        cyc ("cf_reload6", 1, 0, 0, 0, 16'd6, S_RUN, 6, 0, 0);
        idle("cf_5", S_RUN, 5, 0);
        idle("cf_4", S_RUN, 4, 0);
        cyc ("cf_restart9", 1, 0, 0, 0, 16'd9, S_RUN, 9, 0, 0);
        idle("cf_8", S_RUN, 8, 0);
        cyc ("cf_zero_run", 1, 0, 0, 0, 16'd0, S_RUN, 7, 0, 1);
        idle("cf_6", S_RUN, 6, 0);

        // Pause on the terminal tick
        cyc ("tp_load", 1, 0, 0, 0, 16'd2, S_RUN, 2, 0, 0);
        idle("tp_1", S_RUN, 1, 0);
        cyc ("tp_pause", 0, 0, 1, 0, '0, S_PAUSE, 1, 0, 0);
        idle("tp_exp", S_DONE, 0, 1);

        // Periodic with load 1
        cyc ("l1_load", 1, 0, 0, 1, 16'd1, S_RUN, 1, 0, 0);
        idle("l1_0a", S_RUN, 0, 1);
        idle("l1_rl", S_RUN, 1, 0);
        idle("l1_0b", S_RUN, 0, 1);

        // Maximum load value
        cyc ("max_load", 1, 0, 0, 0, 16'hFFFF, S_RUN, 16'hFFFF, 0, 0);
        idle("max_dec", S_RUN, 16'hFFFE, 0);

        // Reset mid-run at count 2
        cyc ("rs_load", 1, 0, 0, 0, 16'd3, S_RUN, 3, 0, 0);
        idle("rs_2", S_RUN, 2, 0);
        drive("rs_rst", 1'b1, 0, 0, 0, 0, '0, S_IDLE, 0, 0, 0);
        idle("rs_after0", S_IDLE, 0, 0);
        idle("rs_after1", S_IDLE, 0, 0);
        idle("rs_after2", S_IDLE, 0, 0);

`ifdef TIMER_CTRL_PRESCALE_EN
        bus_if.presc_val = 8'd2;
        cyc ("ps_load", 1, 0, 0, 0, 16'd2, S_RUN, 2, 0, 0);
        idle("ps_c2", S_RUN, 2, 0);
        idle("ps_c3", S_RUN, 2, 0);
        idle("ps_c4", S_RUN, 1, 0);
        idle("ps_c5", S_RUN, 1, 0);
        idle("ps_c6", S_RUN, 1, 0);
        idle("ps_c7", S_DONE, 0, 1);

        cyc ("psp_load", 1, 0, 0, 0, 16'd2, S_RUN, 2, 0, 0);
        idle("psp_d1", S_RUN, 2, 0);
        cyc ("psp_hold0", 0, 0, 1, 0, '0, S_PAUSE, 2, 0, 0);
        cyc ("psp_hold1", 0, 0, 1, 0, '0, S_PAUSE, 2, 0, 0);
        idle("psp_d2", S_RUN, 2, 0);
        idle("psp_tick", S_RUN, 1, 0);
        idle("psp_d0", S_RUN, 1, 0);
        idle("psp_d1b", S_RUN, 1, 0);
        idle("psp_exp", S_DONE, 0, 1);

        bus_if.presc_val = 8'd0;
        cyc ("p0_load", 1, 0, 0, 0, 16'd2, S_RUN, 2, 0, 0);
        idle("p0_1", S_RUN, 1, 0);
        idle("p0_exp", S_DONE, 0, 1);
`endif

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
